moving_sum_accum: RTL and testbench
===================================

Name: moving_sum_accum

Overview:
- Downstream consumer of the RAM-based variable-depth shift register. Computes a running boxcar (moving-window) sum of the sample stream.
- Each enabled cycle it adds the newest sample entering the shift register and subtracts the sample leaving it (the shift register Q output).
- The window length follows the shift register's ADDR tap setting.
- Feeds decimators and threshold detectors with the window sum and a window-full valid flag.

Parameters:
- DSIZE, 8: sample width, unsigned; matches the shift register data width.
- ASIZE, 4: tap address width; matches the shift register ADDR width.
- TAP_OFFSET, 1: added to ADDR to give the window length N. This is the shift register latency at ADDR=0.
- SSIZE, DSIZE+ASIZE+1: sum width. Wide enough that the sum cannot overflow for any N up to 2^ASIZE-1+TAP_OFFSET.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- Reset, input, 1: synchronous, active-low reset (Reset=0 on a rising clk edge resets the block).
- ce, input, 1: sample enable. Must be the same enable that advances the shift register.
- Din, input, DSIZE: sample entering the shift register this cycle.
- Qdly, input, DSIZE: shift register Q output, i.e. the sample leaving the window this cycle.
- ADDR, input, ASIZE: current tap setting; sets N = ADDR + TAP_OFFSET.
- Sum, output, SSIZE: window sum.
- Sum_valid, output, 1: high once N samples have been accumulated since the last restart.
- Fill_cnt, output, ASIZE+1: number of samples accumulated during warm-up; saturates at N.

Behaviour:
- Reset (Reset=0 on a clk edge):
  - Sum=0, Sum_valid=0, Fill_cnt=0, state=FILL.
  - The registered copy of ADDR (addr_q) loads the current ADDR.
  - Reset takes priority over all other events, including mid-operation.
- States:
  - FILL (warm-up).
  - RUN (window full).
- FILL, on a ce cycle:
  - Sum <= Sum + Din. Qdly is ignored because it holds pre-restart data.
  - Fill_cnt increments.
  - When the incremented count equals N: go to RUN and set Sum_valid=1 in the same edge.
- RUN, on a ce cycle:
  - Sum <= Sum + Din - Qdly, computed at SSIZE width.
  - The sum never underflows if the shift register is consistent. There is no wrap protection; the bench asserts Sum never exceeds N*(2^DSIZE-1).
- ce=0: all registers hold, regardless of Din, Qdly or ADDR activity.
  - Exception: an ADDR change is still detected and restarts the window (see below).
- ADDR change (ADDR != addr_q on a clk edge, with or without ce):
  - Sum<=0, Fill_cnt<=0, Sum_valid<=0, state<=FILL, addr_q<=ADDR.
  - A sample presented with ce on that same edge is discarded. Counting restarts on the next ce cycle.
  - Restart has priority over accumulation.
- Latency:
  - Sum and Sum_valid are registered, one clk after the ce edge that delivers the sample.
  - There is no combinational path from inputs to outputs.
- N=1 (ADDR=0, TAP_OFFSET=1): the first ce cycle after restart goes directly to RUN.
- Fill_cnt holds at N while in RUN.

Optional Feature:
- Macro: MOVSUM_PEAK_EN.
- Defined:
  - Adds input Peak_clr (1 bit) and output Peak (SSIZE).
  - Peak tracks the maximum Sum seen while Sum_valid=1; it updates one clk after Sum.
  - Peak_clr=1, reset, or an ADDR restart sets Peak=0.
  - If Peak_clr and an update occur on the same edge, the clear wins.
- Undefined: the Peak port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package movsum_pkg holds:
  - SSIZE derivation;
  - state encoding (FILL=1'b0, RUN=1'b1);
  - the Fill_cnt width constant.
- One natural sub-module: movsum_fill_ctrl, containing the FILL/RUN FSM, Fill_cnt and ADDR-change detection.
- The top level holds the datapath adder/subtractor and the optional peak register.

Test Plan (DSIZE=8, ASIZE=4, TAP_OFFSET=1; the bench models the shift register as a behavioural ce-gated delay of ADDR+1 samples):
1. Reset low 3 cycles, then high; ce=1; Din ramp 0,1,2,...; ADDR=4 -> Sum_valid rises one clk after the 5th sample with Sum=10. Thereafter Sum=5k-10 for the latest sample k (e.g. k=9 -> 35).
2. Toggle ce 1/0 alternately during the ramp -> Sum, Fill_cnt and Sum_valid are unchanged on ce=0 cycles. Valid is reached after 5 enabled samples.
3. ADDR changes 4->15 mid-RUN -> the next edge gives Sum=0, Sum_valid=0, Fill_cnt=0. Valid returns after 16 ce samples, with Sum equal to the sum of those 16 samples.
4. Reset pulsed low for 1 cycle mid-RUN with ce=1 -> Sum=0, Sum_valid=0 the next clk. Refill to valid after N samples.
5. Constant Din=255, ADDR=15 -> Sum saturates naturally at 4080 with no wrap. ADDR=0 -> Sum_valid on the first sample and Sum equals the current Din each cycle.
6. With MOVSUM_PEAK_EN: ramp then hold Din=0 -> Peak holds the maximum Sum. Assert Peak_clr coincident with a new maximum -> Peak=0.

Source files
------------

// File: rtl/movsum_pkg.sv
// -----------------------------------------------------------------------------
// movsum_pkg
// Shared definitions for the moving-window sum accumulator:
//   - movsum_state_e : warm-up / window-full state encoding
//   - movsum_ssize() : sum width that cannot overflow for the largest window
//   - movsum_fill_w(): width of the fill counter (must hold N = 2^ASIZE)
// -----------------------------------------------------------------------------
package movsum_pkg;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } movsum_state_e;

   // Largest window is 2^ASIZE samples of (2^DSIZE-1); one extra bit gives
   // headroom for a TAP_OFFSET that pushes N just past 2^ASIZE.
   function automatic int movsum_ssize(input int dsize, input int asize);
      return dsize + asize + 1;
   endfunction

   function automatic int movsum_fill_w(input int asize);
      return asize + 1;
   endfunction

endpackage

// File: rtl/movsum_fill_ctrl.sv
// -----------------------------------------------------------------------------
// movsum_fill_ctrl
// Window warm-up controller: FILL/RUN state, fill counter, valid flag and
// detection of tap (ADDR) changes that restart the window.
//
// Ports:
//   clk       in   clock, rising edge
//   Reset     in   synchronous active-low reset
//   ce        in   sample enable (same enable as the shift register)
//   ADDR      in   current tap setting, N = ADDR + TAP_OFFSET
//   restart   out  ADDR differs from the registered copy this cycle
//   state     out  current FSM state
//   fill_cnt  out  samples accumulated since restart, saturates at N
//   sum_valid out  window is full
//
// state | meaning
// ------+----------------------------------------------------------
// FILL  | warm-up: counting samples, leaving sample (Qdly) ignored
// RUN   | window full: add entering sample, subtract leaving sample
// -----------------------------------------------------------------------------
module movsum_fill_ctrl
   import movsum_pkg::*;
#(
   parameter int ASIZE      = 4,
   parameter int TAP_OFFSET = 1,
   parameter int FW         = movsum_fill_w(ASIZE)
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             ce,
   input  logic [ASIZE-1:0] ADDR,
   output logic             restart,
   output movsum_state_e    state,
   output logic [FW-1:0]    fill_cnt,
   output logic             sum_valid
);

   logic [ASIZE-1:0] addr_q;
   logic [FW-1:0]    win_len;
   logic [FW-1:0]    cnt_inc;
   logic [FW-1:0]    cnt_d;
   logic             valid_d;
   movsum_state_e    state_d;

   assign win_len = {1'b0, addr_q} + FW'(TAP_OFFSET);
   assign cnt_inc = fill_cnt + FW'(1);

   // A tap change is seen regardless of ce, since the window length is
   // no longer what the accumulated sum represents.
   assign restart = (ADDR != addr_q);

   always_comb begin
      state_d = state;
      cnt_d   = fill_cnt;
      valid_d = sum_valid;
      if (restart) begin
         state_d = FILL;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else if (ce) begin
         case (state)
            FILL: begin
               cnt_d = cnt_inc;
               if (cnt_inc == win_len) begin
                  state_d = RUN;
                  valid_d = 1'b1;
               end
            end
            RUN: begin
               cnt_d = fill_cnt;
            end
            default: begin
               state_d = FILL;
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state     <= FILL;
         fill_cnt  <= '0;
         sum_valid <= 1'b0;
         addr_q    <= ADDR;
      end else begin
         state     <= state_d;
         fill_cnt  <= cnt_d;
         sum_valid <= valid_d;
         addr_q    <= ADDR;
      end
   end

endmodule

// File: rtl/moving_sum_accum.sv
// -----------------------------------------------------------------------------
// moving_sum_accum
// Running boxcar sum over the last N samples of a stream that also feeds a
// RAM-based variable-depth shift register. Each enabled cycle adds the
// entering sample (Din) and, once the window is full, subtracts the sample
// leaving the shift register (Qdly). N = ADDR + TAP_OFFSET.
//
// Optional build macro: MOVSUM_PEAK_EN adds Peak_clr / Peak, a register
// holding the largest Sum seen while Sum_valid is high.
//
// Ports:
//   clk       in   clock, rising edge
//   Reset     in   synchronous active-low reset
//   ce        in   sample enable (shared with the shift register)
//   Peak_clr  in   clear Peak (MOVSUM_PEAK_EN only)
//   Din       in   sample entering the window
//   Qdly      in   sample leaving the window (shift register Q)
//   ADDR      in   tap setting
//   Sum       out  registered window sum
//   Sum_valid out  window holds N samples
//   Peak      out  maximum valid Sum (MOVSUM_PEAK_EN only)
//   Fill_cnt  out  samples accumulated during warm-up, saturates at N
// -----------------------------------------------------------------------------
module moving_sum_accum
   import movsum_pkg::*;
#(
   parameter int DSIZE      = 8,
   parameter int ASIZE      = 4,
   parameter int TAP_OFFSET = 1,
   parameter int SSIZE      = movsum_ssize(DSIZE, ASIZE)
) (
   input  logic                       clk,
   input  logic                       Reset,
   input  logic                       ce,
`ifdef MOVSUM_PEAK_EN
   input  logic                       Peak_clr,
`endif
   input  logic [DSIZE-1:0]           Din,
   input  logic [DSIZE-1:0]           Qdly,
   input  logic [ASIZE-1:0]           ADDR,
   output logic [SSIZE-1:0]           Sum,
   output logic                       Sum_valid,
`ifdef MOVSUM_PEAK_EN
   output logic [SSIZE-1:0]           Peak,
`endif
   output logic [movsum_fill_w(ASIZE)-1:0] Fill_cnt
);

   localparam int FW = movsum_fill_w(ASIZE);

   logic          restart;
   movsum_state_e state;
   logic [SSIZE-1:0] sum_d;

   movsum_fill_ctrl #(
      .ASIZE      (ASIZE),
      .TAP_OFFSET (TAP_OFFSET),
      .FW         (FW)
   ) u_fill_ctrl (
      .clk       (clk),
      .Reset     (Reset),
      .ce        (ce),
      .ADDR      (ADDR),
      .restart   (restart),
      .state     (state),
      .fill_cnt  (Fill_cnt),
      .sum_valid (Sum_valid)
   );

   // During FILL the shift register still outputs pre-restart samples, so
   // Qdly is only subtracted once the window is full.
   always_comb begin
      sum_d = Sum;
      if (restart) begin
         sum_d = '0;
      end else if (ce) begin
         if (state == RUN) begin
            sum_d = Sum + SSIZE'(Din) - SSIZE'(Qdly);
         end else begin
            sum_d = Sum + SSIZE'(Din);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         Sum <= '0;
      end else begin
         Sum <= sum_d;
      end
   end

`ifdef MOVSUM_PEAK_EN
   // Compares the registered Sum, so Peak lags Sum by one clock.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         Peak <= '0;
      end else if (Peak_clr || restart) begin
         Peak <= '0;
      end else if (Sum_valid && (Sum > Peak)) begin
         Peak <= Sum;
      end
   end
`endif

endmodule

// File: tb/tb_moving_sum_accum.sv
module tb_moving_sum_accum;

   localparam int DSIZE = 8;
   localparam int ASIZE = 4;
   localparam int SSIZE = DSIZE + ASIZE + 1;
   localparam int FW    = ASIZE + 1;

   logic             clk = 1'b0;
   logic             Reset;
   logic             ce;
   logic [DSIZE-1:0] Din;
   logic [DSIZE-1:0] Qdly;
   logic [ASIZE-1:0] ADDR;
   logic [SSIZE-1:0] Sum;
   logic             Sum_valid;
   logic [FW-1:0]    Fill_cnt;
`ifdef MOVSUM_PEAK_EN
   logic             Peak_clr;
   logic [SSIZE-1:0] Peak;
`endif

   always #5 clk = ~clk;

   moving_sum_accum #(
      .DSIZE      (DSIZE),
      .ASIZE      (ASIZE),
      .TAP_OFFSET (1)
   ) dut (
      .clk       (clk),
      .Reset     (Reset),
      .ce        (ce),
`ifdef MOVSUM_PEAK_EN
      .Peak_clr  (Peak_clr),
`endif
      .Din       (Din),
      .Qdly      (Qdly),
      .ADDR      (ADDR),
      .Sum       (Sum),
      .Sum_valid (Sum_valid),
`ifdef MOVSUM_PEAK_EN
      .Peak      (Peak),
`endif
      .Fill_cnt  (Fill_cnt)
   );

   typedef struct {
      int sum;
      bit valid;
      int cnt;
      int peak;
      int bound;
   } exp_t;

   exp_t sb[$];
   int   acc[$];
   int   hist[32];
   int   m_addr     = 0;
   int   m_peak     = 0;
   int   prev_sum   = 0;
   bit   prev_valid = 1'b0;
   int   errors     = 0;
   int   checks     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock: drive inputs at negedge, model the edge, push the expectation,
   // then pop and compare 1 time unit after the rising edge.
   task automatic step(input bit rst, input bit ce_i, input int din, input int addr,
                       input bit pclr = 1'b0);
      exp_t e;
      int   n;
      int   s;
      @(negedge clk);
      Reset = rst;
      ce    = ce_i;
      Din   = DSIZE'(din);
      ADDR  = ASIZE'(addr);
      Qdly  = DSIZE'(hist[addr]);
`ifdef MOVSUM_PEAK_EN
      Peak_clr = pclr;
`endif
      if (!rst || pclr || (addr != m_addr)) m_peak = 0;
      else if (prev_valid && (prev_sum > m_peak)) m_peak = prev_sum;

      if (!rst || (addr != m_addr)) begin
         acc.delete();
         m_addr = addr;
      end else if (ce_i) begin
         acc.push_back(din);
      end
      if (ce_i) begin
         for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = din;
      end

      n = m_addr + 1;
      while (acc.size() > n) void'(acc.pop_front());
      s = 0;
      foreach (acc[i]) s += acc[i];
      e.sum   = s;
      e.valid = (acc.size() == n);
      e.cnt   = acc.size();
      e.peak  = m_peak;
      e.bound = n * 255;
      sb.push_back(e);
      prev_sum   = s;
      prev_valid = e.valid;

      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("sum", 32'(Sum), e.sum);
      check("sum_valid", 32'(Sum_valid), 32'(e.valid));
      check("fill_cnt", 32'(Fill_cnt), e.cnt);
      check("sum_bound", 32'(Sum <= SSIZE'(e.bound)), 1);
`ifdef MOVSUM_PEAK_EN
      check("peak", 32'(Peak), e.peak);
`endif
   endtask

   initial begin
      for (int i = 0; i < 32; i++) hist[i] = 0;
      Reset = 1'b0;
      ce    = 1'b0;
      Din   = '0;
      Qdly  = '0;
      ADDR  = '0;
`ifdef MOVSUM_PEAK_EN
      Peak_clr = 1'b0;
`endif

      // 1: reset then ramp, N=5
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 4);
      check("reset_sum", 32'(Sum), 0);
      check("reset_valid", 32'(Sum_valid), 0);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b1, k, 4);
         if (k == 3) check("t1_not_valid_at_4", 32'(Sum_valid), 0);
         if (k == 4) begin
            check("t1_valid_at_5", 32'(Sum_valid), 1);
            check("t1_first_sum", 32'(Sum), 10);
         end
      end
      check("t1_sum_k9", 32'(Sum), 35);
      check("t1_fill_sat", 32'(Fill_cnt), 5);

      // 2: alternating ce, garbage on disabled cycles
      step(1'b0, 1'b0, 0, 4);
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) step(1'b1, 1'b1, 10 + i / 2, 4);
         else            step(1'b1, 1'b0, 200 + i, 4);
         if (i == 7) check("t2_not_valid", 32'(Sum_valid), 0);
         if (i == 8) check("t2_valid_sum", 32'(Sum), 60);
         if (i == 9) check("t2_hold_sum", 32'(Sum), 60);
      end

      // 3: tap change 4 -> 15 mid-RUN
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 20 + i, 4);
      step(1'b1, 1'b1, 99, 15);
      check("t3_restart_sum", 32'(Sum), 0);
      check("t3_restart_valid", 32'(Sum_valid), 0);
      check("t3_restart_cnt", 32'(Fill_cnt), 0);
      for (int j = 0; j < 16; j++) begin
         step(1'b1, 1'b1, 30 + j, 15);
         if (j == 14) check("t3_not_valid_15", 32'(Sum_valid), 0);
      end
      check("t3_valid_sum", 32'(Sum), 600);
      for (int j = 0; j < 4; j++) step(1'b1, 1'b1, 50 + 3 * j, 15);

      // 4: reset pulse mid-RUN with ce
      step(1'b0, 1'b1, 7, 15);
      check("t4_reset_sum", 32'(Sum), 0);
      check("t4_reset_valid", 32'(Sum_valid), 0);
      for (int j = 0; j < 16; j++) step(1'b1, 1'b1, 1, 15);
      check("t4_refill_sum", 32'(Sum), 16);

      // 5: full-scale input, then N=1
      for (int j = 0; j < 20; j++) step(1'b1, 1'b1, 255, 15);
      check("t5_full_scale", 32'(Sum), 4080);
      step(1'b1, 1'b1, 9, 0);
      check("t5_restart_n1", 32'(Sum), 0);
      step(1'b1, 1'b1, 3, 0);
      check("t5_n1_valid", 32'(Sum_valid), 1);
      check("t5_n1_sum_a", 32'(Sum), 3);
      step(1'b1, 1'b1, 200, 0);
      check("t5_n1_sum_b", 32'(Sum), 200);
      step(1'b1, 1'b0, 77, 0);
      check("t5_n1_hold", 32'(Sum), 200);
      step(1'b1, 1'b1, 17, 0);
      check("t5_n1_sum_c", 32'(Sum), 17);

`ifdef MOVSUM_PEAK_EN
      // 6: peak tracking and clear priority, N=3
      step(1'b1, 1'b1, 10, 2);
      step(1'b1, 1'b1, 10, 2);
      step(1'b1, 1'b1, 20, 2);
      step(1'b1, 1'b1, 30, 2);
      step(1'b1, 1'b1, 40, 2);
      for (int j = 0; j < 5; j++) step(1'b1, 1'b1, 0, 2);
      check("t6_peak_hold", 32'(Peak), 90);
      step(1'b1, 1'b1, 100, 2);
      step(1'b1, 1'b1, 100, 2, 1'b1);
      check("t6_peak_clr_wins", 32'(Peak), 0);
      step(1'b1, 1'b1, 100, 2);
      step(1'b1, 1'b1, 0, 2);
      check("t6_peak_after_clr", 32'(Peak), 300);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
